// File: rtl/uart_transceiver_if.sv
// Host and serial signals of the UART transceiver.
// master = host/line side, slave = the transceiver.
interface uart_transceiver_if #(
   parameter int DBIT = 8
);
   logic            i_rd_uart;
   logic            i_wr_uart;
   logic            i_rx;
   logic [DBIT-1:0] i_w_data;
   logic            o_tx_full;
   logic            o_rx_empty;
   logic            o_tx;
   logic [DBIT-1:0] o_r_data;

   modport master (
      output i_rd_uart, i_wr_uart, i_rx, i_w_data,
      input  o_tx_full, o_rx_empty, o_tx, o_r_data
   );

   modport slave (
      input  i_rd_uart, i_wr_uart, i_rx, i_w_data,
      output o_tx_full, o_rx_empty, o_tx, o_r_data
   );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 16x-oversampled UART with one FIFO per direction.
// Define UART_LOOPBACK_EN to feed the TX line into the receiver.
module uart_transceiver #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 326,
   parameter int FIFO_W  = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   uart_transceiver_if.slave bus
);
   localparam int NW    = $clog2(DBIT);
   localparam int DEPTH = 1 << FIFO_W;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0] baud_cnt;
   logic        tick;

   assign tick = (baud_cnt == 16'(DVSR - 1));

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) baud_cnt <= '0;
      else         baud_cnt <= tick ? '0 : baud_cnt + 16'd1;

   // ---------------- receiver ----------------
   state_t          rx_st, rx_st_n;
   logic [4:0]      rx_s, rx_s_n;
   logic [NW-1:0]   rx_n, rx_n_n;
   logic [DBIT-1:0] rx_b, rx_b_n;
   logic            rx_done, rx_in;
   logic            tx_q;

`ifdef UART_LOOPBACK_EN
   assign rx_in = tx_q;
`else
   assign rx_in = bus.i_rx;
`endif

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         rx_st <= IDLE;
         rx_s  <= '0;
         rx_n  <= '0;
         rx_b  <= '0;
      end else begin
         rx_st <= rx_st_n;
         rx_s  <= rx_s_n;
         rx_n  <= rx_n_n;
         rx_b  <= rx_b_n;
      end

   always_comb begin
      rx_st_n = rx_st;
      rx_s_n  = rx_s;
      rx_n_n  = rx_n;
      rx_b_n  = rx_b;
      rx_done = 1'b0;
      unique case (rx_st)
         IDLE:
            if (!rx_in) begin
               rx_st_n = START;
               rx_s_n  = '0;
            end
         START:
            if (tick) begin
               if (rx_s == 5'd7) begin
                  rx_st_n = DATA;
                  rx_s_n  = '0;
                  rx_n_n  = '0;
               end else rx_s_n = rx_s + 5'd1;
            end
         DATA:
            if (tick) begin
               if (rx_s == 5'd15) begin
                  rx_s_n = '0;
                  rx_b_n = {rx_in, rx_b[DBIT-1:1]};
                  if (rx_n == NW'(DBIT - 1)) rx_st_n = STOP;
                  else rx_n_n = rx_n + NW'(1);
               end else rx_s_n = rx_s + 5'd1;
            end
         STOP:
            if (tick) begin
               if (rx_s == 5'(SB_TICK - 1)) begin
                  rx_st_n = IDLE;
                  rx_done = 1'b1;
               end else rx_s_n = rx_s + 5'd1;
            end
         default: rx_st_n = IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [DBIT-1:0]   rx_mem [DEPTH];
   logic [FIFO_W-1:0] rf_w, rf_r;
   logic              rf_full, rf_empty, rf_do_w, rf_do_r;

   // A full FIFO still accepts a write when the same clock frees a slot.
   assign rf_do_w = rx_done & (!rf_full | bus.i_rd_uart);
   assign rf_do_r = bus.i_rd_uart & !rf_empty;

   always_ff @(posedge i_clk)
      if (rf_do_w) rx_mem[rf_w] <= rx_b;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         rf_w     <= '0;
         rf_r     <= '0;
         rf_full  <= 1'b0;
         rf_empty <= 1'b1;
      end else begin
         if (rf_do_w) rf_w <= rf_w + FIFO_W'(1);
         if (rf_do_r) rf_r <= rf_r + FIFO_W'(1);
         if (rf_do_w && !rf_do_r) begin
            rf_empty <= 1'b0;
            rf_full  <= ((rf_w + FIFO_W'(1)) == rf_r);
         end else if (rf_do_r && !rf_do_w) begin
            rf_full  <= 1'b0;
            rf_empty <= ((rf_r + FIFO_W'(1)) == rf_w);
         end
      end

   assign bus.o_r_data   = rx_mem[rf_r];
   assign bus.o_rx_empty = rf_empty;

   // ---------------- TX FIFO ----------------
   logic [DBIT-1:0]   tx_mem [DEPTH];
   logic [FIFO_W-1:0] tf_w, tf_r;
   logic              tf_full, tf_empty, tf_do_w, tf_do_r, tx_rd;

   assign tf_do_w = bus.i_wr_uart & (!tf_full | tx_rd);
   assign tf_do_r = tx_rd & !tf_empty;

   always_ff @(posedge i_clk)
      if (tf_do_w) tx_mem[tf_w] <= bus.i_w_data;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         tf_w     <= '0;
         tf_r     <= '0;
         tf_full  <= 1'b0;
         tf_empty <= 1'b1;
      end else begin
         if (tf_do_w) tf_w <= tf_w + FIFO_W'(1);
         if (tf_do_r) tf_r <= tf_r + FIFO_W'(1);
         if (tf_do_w && !tf_do_r) begin
            tf_empty <= 1'b0;
            tf_full  <= ((tf_w + FIFO_W'(1)) == tf_r);
         end else if (tf_do_r && !tf_do_w) begin
            tf_full  <= 1'b0;
            tf_empty <= ((tf_r + FIFO_W'(1)) == tf_w);
         end
      end

   assign bus.o_tx_full = tf_full;

   // ---------------- transmitter ----------------
   state_t          tx_st, tx_st_n;
   logic [4:0]      tx_s, tx_s_n;
   logic [NW-1:0]   tx_n, tx_n_n;
   logic [DBIT-1:0] tx_b, tx_b_n;
   logic            tx_d;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         tx_st <= IDLE;
         tx_s  <= '0;
         tx_n  <= '0;
         tx_b  <= '0;
         tx_q  <= 1'b1;
      end else begin
         tx_st <= tx_st_n;
         tx_s  <= tx_s_n;
         tx_n  <= tx_n_n;
         tx_b  <= tx_b_n;
         tx_q  <= tx_d;
      end

   // tx_d is the line level for the next clock, so it leads state changes.
   always_comb begin
      tx_st_n = tx_st;
      tx_s_n  = tx_s;
      tx_n_n  = tx_n;
      tx_b_n  = tx_b;
      tx_d    = tx_q;
      tx_rd   = 1'b0;
      unique case (tx_st)
         IDLE: begin
            tx_d = 1'b1;
            if (!tf_empty) begin
               tx_rd   = 1'b1;
               tx_b_n  = tx_mem[tf_r];
               tx_s_n  = '0;
               tx_d    = 1'b0;
               tx_st_n = START;
            end
         end
         START:
            if (tick) begin
               if (tx_s == 5'd15) begin
                  tx_s_n  = '0;
                  tx_n_n  = '0;
                  tx_d    = tx_b[0];
                  tx_st_n = DATA;
               end else tx_s_n = tx_s + 5'd1;
            end
         DATA:
            if (tick) begin
               if (tx_s == 5'd15) begin
                  tx_s_n = '0;
                  tx_b_n = tx_b >> 1;
                  if (tx_n == NW'(DBIT - 1)) begin
                     tx_d    = 1'b1;
                     tx_st_n = STOP;
                  end else begin
                     tx_d   = tx_b[1];
                     tx_n_n = tx_n + NW'(1);
                  end
               end else tx_s_n = tx_s + 5'd1;
            end
         STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (tx_s == 5'(SB_TICK - 1)) tx_st_n = IDLE;
               else tx_s_n = tx_s + 5'd1;
            end
         end
         default: tx_st_n = IDLE;
      endcase
   end

   assign bus.o_tx = tx_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: framing, loopback, FIFO limits.
`timescale 1ns/1ps
module tb_uart_transceiver;
   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int DVSR    = 4;
   localparam int FIFO_W  = 5;
   localparam int BITC    = 16 * DVSR;
   localparam int FRAME   = (1 + DBIT) * BITC + SB_TICK * DVSR;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic loop_en = 1'b0;
   logic rx_drv = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   uart_transceiver_if #(.DBIT(DBIT)) uif();

   assign uif.i_rx = loop_en ? uif.o_tx : rx_drv;

   uart_transceiver #(
      .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .FIFO_W(FIFO_W)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .bus(uif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      uif.i_w_data  = d;
      uif.i_wr_uart = 1'b1;
      @(negedge clk);
      uif.i_wr_uart = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      uif.i_rd_uart = 1'b1;
      @(negedge clk);
      uif.i_rd_uart = 1'b0;
   endtask

   task automatic wait_fall(output logic found);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (uif.o_tx == 1'b0) found = 1'b1;
      end
   endtask

   logic [7:0] lb [10] = '{8'hFF, 8'h02, 8'h03, 8'h0A, 8'h0A,
                           8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A};
   logic [7:0] pat = 8'h55;

   initial begin
      logic found;
      int   d, cnt, lows;
      uif.i_rd_uart = 1'b0;
      uif.i_wr_uart = 1'b0;
      uif.i_w_data  = '0;

      // reset: half-clock async pulse
      #2 rst = 1'b1;
      #5 rst = 1'b0;
      @(negedge clk);
      check("rst_tx", uif.o_tx, 1'b1);
      check("rst_rx_empty", uif.o_rx_empty, 1'b1);
      check("rst_tx_full", uif.o_tx_full, 1'b0);

      // frame format of 0x55 on the pin
      push(pat);
      wait_fall(found);
      check("fmt_fall", found, 1'b1);
      d = 0;
      while (uif.o_tx == 1'b0 && d < 2 * BITC) begin
         d++;
         @(negedge clk);
      end
      check("fmt_start_len", (d >= BITC - DVSR + 1) && (d <= BITC), 1'b1);
      for (int k = 0; k < DBIT; k++) begin
         repeat ((k == 0) ? BITC / 2 : BITC) @(negedge clk);
         check($sformatf("fmt_bit%0d", k), uif.o_tx, pat[k]);
      end
      repeat (BITC) @(negedge clk);
      check("fmt_stop", uif.o_tx, 1'b1);
      repeat (BITC) @(negedge clk);
      check("fmt_no_rx", uif.o_rx_empty, 1'b1);

      // loopback of 10 bytes
      loop_en = 1'b1;
      for (int i = 0; i < 10; i++) push(lb[i]);
      repeat (10 * FRAME + 100) @(negedge clk);
      check("lb_nonempty", uif.o_rx_empty, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("lb_data%0d", i), uif.o_r_data, lb[i]);
         pop();
      end
      check("lb_empty", uif.o_rx_empty, 1'b1);

      // pop coinciding with a receive on a non-empty FIFO
      push(8'h11);
      push(8'h22);
      push(8'h33);
      cnt   = 0;
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         @(negedge clk);
         if (dut.rx_done) begin
            cnt++;
            if (cnt == 3) begin
               check("sim_head", uif.o_r_data, 8'h11);
               uif.i_rd_uart = 1'b1;
               @(negedge clk);
               uif.i_rd_uart = 1'b0;
               found = 1'b1;
            end
         end
      end
      check("sim_seen", found, 1'b1);
      check("sim_d0", uif.o_r_data, 8'h22);
      pop();
      check("sim_d1", uif.o_r_data, 8'h33);
      check("sim_not_empty", uif.o_rx_empty, 1'b0);
      pop();
      check("sim_empty", uif.o_rx_empty, 1'b1);

      // TX FIFO full and RX overflow
      push(8'h40);
      repeat (4) @(negedge clk);
      check("tf_after_load", uif.o_tx_full, 1'b0);
      for (int i = 1; i < 32; i++) push(8'(8'h40 + i));
      check("tf_31", uif.o_tx_full, 1'b0);
      push(8'h60);
      check("tf_32", uif.o_tx_full, 1'b1);
      push(8'h61);
      check("tf_33_ignored", uif.o_tx_full, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         @(negedge clk);
         if (!uif.o_tx_full) found = 1'b1;
      end
      check("tf_clear", found, 1'b1);
      repeat (32 * FRAME + 200) @(negedge clk);
      check("ovf_tx_idle", uif.o_tx, 1'b1);
      check("ovf_head", uif.o_r_data, 8'h40);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("ovf_d%0d", i), uif.o_r_data, 8'(8'h40 + i));
         pop();
      end
      check("ovf_dropped", uif.o_rx_empty, 1'b1);

      // reset mid-frame
      loop_en = 1'b0;
      push(8'hA5);
      wait_fall(found);
      check("mr_fall", found, 1'b1);
      repeat (10) @(negedge clk);
      check("mr_low", uif.o_tx, 1'b0);
      rst = 1'b1;
      #1;
      check("mr_tx_async", uif.o_tx, 1'b1);
      check("mr_rx_empty", uif.o_rx_empty, 1'b1);
      #3 rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (uif.o_tx == 1'b0) lows++;
      end
      check("mr_aborted", lows, 0);
      check("mr_tx_full", uif.o_tx_full, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
